cram_access_arbiter: RTL and testbench
======================================

// Module: cram_access_arbiter
// PURPOSE
//  Sole owner of the color RAM port (1024x16, synchronous read, 1-cycle read latency).
//  Shares that port between two requesters: per-pixel video palette lookups and 68010 CPU
//  read/write cycles. Video has priority. CPU gets free cycles, with a DTACK-style ack.
//  A starvation guard forces a CPU slot when the CPU has waited too long.
//  Sits between the address decoder / video bus and the four 2149 RAM slices.
// PARAMETERS
//  AW        10   color RAM address width
//  DW        16   color RAM data width
//  MAX_WAIT  255  CPU wait cycles before a video slot is stolen (1..2**12-1)
// PORTS
//  clk        in   1   system clock; the only clock
//  rst_b      in   1   async active-low reset
//  pix_req    in   1   video lookup request this cycle (1-cycle strobe)
//  pix_addr   in   AW  palette index {CRAS, mux select}
//  pix_valid  out  1   pix_data valid this cycle
//  pix_data   out  DW  color word to monitor interface
//  pix_stolen out  1   with pix_valid: slot was stolen, pix_data is repeated
//  cpu_req    in   1   CPU access request (level, held until cpu_ack)
//  cpu_we     in   1   1=write, 0=read (BR_W_b inverted); stable while cpu_req
//  cpu_addr   in   AW  CPU word address (MA)
//  cpu_wdata  in   DW  write data (VBD_in)
//  cpu_ack    out  1   1-cycle acknowledge (DTACK)
//  cpu_rdata  out  DW  read data; valid with cpu_ack on reads
//  cpu_starve out  1   sticky flag, set by a steal event; cleared by reset only
//  ram_addr   out  AW  RAM address (combinational from the grant)
//  ram_we     out  1   RAM write enable (combinational)
//  ram_wdata  out  DW  RAM write data
//  ram_rdata  in   DW  RAM read data for the address presented last cycle
//  init_busy  out  1   clear sweep in progress (CRAM_CLEAR_EN only; else 0)
// BEHAVIOUR
//  Reset: every output register = 0; state = S_CLEAR if CRAM_CLEAR_EN, else S_IDLE;
//   wait counter = 0; read tag pipe empty.
//  Grant, evaluated each cycle in this order:
//   1. S_CLEAR owns the port.
//   2. Steal: if wait_cnt == MAX_WAIT and the CPU is eligible, the CPU wins even when pix_req=1.
//   3. Video wins whenever pix_req=1.
//   4. Otherwise the CPU wins when eligible (state S_IDLE and cpu_req=1).
//  Read tag pipe: 1 stage {valid, owner}. ram_rdata in cycle N+1 belongs to the grant in cycle N.
//  Video latency: pix_req at N -> pix_valid, pix_data registered from ram_rdata, at N+2.
//   Exactly one pix_valid per pix_req, including stolen slots.
//  Stolen slot: no RAM read is issued. At N+2: pix_valid=1, pix_stolen=1, pix_data = previous pix_data.
//  CPU write granted at N: ram_we=1 at N -> cpu_ack at N+1.
//  CPU read granted at N: cpu_ack and cpu_rdata at N+2.
//  Read-after-write to the same address returns the new data.
//  FSM: S_CLEAR -> S_IDLE -(CPU grant, rd)-> S_RD -> S_ACK -> S_REL
//       S_IDLE -(CPU grant, wr)-> S_ACK
//       S_REL -(cpu_req==0)-> S_IDLE
//   S_REL stops one held request from being served twice.
//  wait_cnt: increments each cycle in S_IDLE with cpu_req=1 and no grant; saturates at MAX_WAIT.
//   Resets to 0 on a CPU grant or when cpu_req=0.
//  cpu_req dropped before grant: no RAM access, no ack. Dropped after grant: the access completes
//   and the ack is still issued.
//  Address wrap: none; the AW-bit address covers the whole RAM.
//  Async reset mid-access: in-flight pixel and CPU results are discarded, no ack is issued,
//   and a write already strobed is not undone.
// CONFIGURATION
//  `CRAM_CLEAR_EN defined:
//   - After reset, S_CLEAR writes 0 to addresses 0..2**AW-1, one per cycle (1024 cycles).
//   - init_busy=1 throughout the sweep.
//   - pix_req is answered at N+2 with pix_valid=1 and pix_data=0.
//   - cpu_req is held off (no ack) until the sweep ends, then served normally.
//  `CRAM_CLEAR_EN undefined: no S_CLEAR state, init_busy tied 0, S_IDLE entered directly from reset.
// STRUCTURE
//  cram_pkg:
//   - AW/DW defaults
//   - typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_ACK, S_REL} cram_state_t
//   - typedef enum logic {OWN_VID, OWN_CPU} cram_owner_t
//   - typedef struct {valid, owner, stolen} cram_tag_t
//  Sub-module cram_rd_pipe: tag register plus result routing to the pix_* / cpu_* outputs.
//  FSM, wait counter and grant mux stay in cram_access_arbiter.
// TESTING
//  1. pix_req every cycle for 16 cycles, addr 0..15, RAM preloaded with data=addr*3
//     -> pix_valid 16 cycles starting at +2, data 0,3,...,45, no cpu_ack.
//  2. Idle video; CPU write 0x3FF<=0xBEEF, then read 0x3FF
//     -> write ack at +1, ram_we one cycle; read ack at +2, rdata 0xBEEF.
//  3. pix_req on alternate cycles, CPU read held
//     -> CPU granted in the first gap, ack 2 cycles later, pixel stream uninterrupted.
//  4. MAX_WAIT=4, pix_req constant, CPU write pending
//     -> steal on the 5th cycle, pix_stolen=1 with repeated data, cpu_ack, cpu_starve set and stays set.
//  5. cpu_req held high after ack for 5 cycles -> exactly one ack, FSM stays in S_REL until req drops.
//  6. `CRAM_CLEAR_EN: reset with RAM full of 0xFFFF -> init_busy 1024 cycles, then all reads 0;
//     CPU read issued mid-sweep acks only after the sweep. Rerun with macro undefined -> init_busy 0.

Source files
------------

// File: rtl/cram_pkg.sv
// Shared types and constants for the color RAM access arbiter.
//
// Contents:
//   CRAM_AW / CRAM_DW   default address / data widths of the color RAM
//   CRAM_WAIT_W         width of the CPU starvation wait counter
//   cram_state_t        arbiter FSM states
//   cram_owner_t        which requester a read in flight belongs to
//   cram_tag_t          one read-pipe stage: {valid, owner, stolen, blank}
//   wait_next()         saturating increment for the wait counter
package cram_pkg;

    localparam int CRAM_AW     = 10;
    localparam int CRAM_DW     = 16;
    localparam int CRAM_WAIT_W = 12;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RD    = 3'd2,
        S_ACK   = 3'd3,
        S_REL   = 3'd4
    } cram_state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } cram_owner_t;

    // stolen: a pixel answer without RAM data is also due in this slot
    //         (its owner may still be the CPU if the thief was a CPU read).
    // blank : the pixel answer must be 0 (lookup during the clear sweep).
    typedef struct packed {
        logic        valid;
        cram_owner_t owner;
        logic        stolen;
        logic        blank;
    } cram_tag_t;

    localparam cram_tag_t CRAM_TAG_IDLE = '{valid: 1'b0, owner: OWN_VID,
                                            stolen: 1'b0, blank: 1'b0};

    // Saturating increment, never exceeding max_cnt
    function automatic logic [CRAM_WAIT_W-1:0] wait_next(
        input logic [CRAM_WAIT_W-1:0] cnt,
        input logic [CRAM_WAIT_W-1:0] max_cnt
    );
        if (cnt >= max_cnt) begin
            return max_cnt;
        end else begin
            return cnt + 12'd1;
        end
    endfunction

endpackage

// File: rtl/cram_rd_pipe.sv
// Read tag pipe and result routing for the color RAM arbiter.
//
// The tag captured in cycle N describes what ram_rdata means in cycle N+1;
// results are registered once more so that reads and pixel lookups appear
// at N+2. CPU write acks bypass the tag and appear at N+1.
//
// Ports:
//   clk, rst_b        clock, async active-low reset
//   tag_in            tag of the grant made this cycle
//   cpu_wr_done       a CPU write was strobed this cycle
//   ram_rdata         RAM data for the address presented last cycle
//   pix_valid/_data/_stolen   registered video results
//   cpu_ack, cpu_rdata        registered CPU acknowledge and read data
module cram_rd_pipe
    import cram_pkg::*;
#(
    parameter int DW = CRAM_DW
) (
    input  logic          clk,
    input  logic          rst_b,
    input  cram_tag_t     tag_in,
    input  logic          cpu_wr_done,
    input  logic [DW-1:0] ram_rdata,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    output logic          pix_stolen,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata
);

    cram_tag_t     tag_r;
    logic          pix_valid_r;
    logic          pix_stolen_r;
    logic [DW-1:0] pix_data_r;
    logic          cpu_ack_r;
    logic [DW-1:0] cpu_rdata_r;

    logic          vid_done_s;
    logic          cpu_rd_done_s;
    logic [DW-1:0] pix_data_nxt_s;
    logic [DW-1:0] cpu_rdata_nxt_s;

    // Decode the tag in flight into next register values
    always_comb begin
        // A stolen slot owes a pixel answer even when the CPU owns the read
        vid_done_s    = tag_r.valid && ((tag_r.owner == OWN_VID) || tag_r.stolen);
        cpu_rd_done_s = tag_r.valid && (tag_r.owner == OWN_CPU);

        if (!vid_done_s) begin
            pix_data_nxt_s = pix_data_r;
        end else if (tag_r.stolen) begin
            pix_data_nxt_s = pix_data_r;    // repeat the previous color
        end else if (tag_r.blank) begin
            pix_data_nxt_s = {DW{1'b0}};
        end else begin
            pix_data_nxt_s = ram_rdata;
        end

        if (cpu_rd_done_s) begin
            cpu_rdata_nxt_s = ram_rdata;
        end else begin
            cpu_rdata_nxt_s = cpu_rdata_r;
        end
    end

    // Tag stage and registered result outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_r        <= CRAM_TAG_IDLE;
            pix_valid_r  <= 1'b0;
            pix_stolen_r <= 1'b0;
            pix_data_r   <= {DW{1'b0}};
            cpu_ack_r    <= 1'b0;
            cpu_rdata_r  <= {DW{1'b0}};
        end else begin
            tag_r        <= tag_in;
            pix_valid_r  <= vid_done_s;
            pix_stolen_r <= vid_done_s && tag_r.stolen;
            pix_data_r   <= pix_data_nxt_s;
            cpu_ack_r    <= cpu_wr_done || cpu_rd_done_s;
            cpu_rdata_r  <= cpu_rdata_nxt_s;
        end
    end

    assign pix_valid  = pix_valid_r;
    assign pix_stolen = pix_stolen_r;
    assign pix_data   = pix_data_r;
    assign cpu_ack    = cpu_ack_r;
    assign cpu_rdata  = cpu_rdata_r;

endmodule

// File: rtl/cram_access_arbiter.sv
// Color RAM access arbiter: sole owner of the 1024x16 color RAM port.
//
// Video palette lookups have priority; the 68010 CPU uses free cycles and
// gets a DTACK-style one-cycle ack. When the CPU has waited MAX_WAIT cycles
// it steals a video slot; the robbed lookup is answered with the previous
// color and pix_stolen=1, and cpu_starve is latched until reset.
//
// Optional build macro: CRAM_CLEAR_EN -- after reset the RAM is swept to 0,
// one address per cycle, with init_busy=1; lookups read 0, the CPU waits.
//
// Ports:
//   clk, rst_b                        clock, async active-low reset
//   pix_req, pix_addr                 video lookup strobe and palette index
//   pix_valid, pix_data, pix_stolen   video result, 2 cycles after pix_req
//   cpu_req, cpu_we, cpu_addr, cpu_wdata   CPU access (level request)
//   cpu_ack, cpu_rdata                CPU acknowledge and read data
//   cpu_starve                        sticky: a video slot was stolen
//   ram_addr, ram_we, ram_wdata       RAM port (combinational from the grant)
//   ram_rdata                         RAM data for last cycle's address
//   init_busy                         clear sweep in progress
module cram_access_arbiter
    import cram_pkg::*;
#(
    parameter int AW       = CRAM_AW,
    parameter int DW       = CRAM_DW,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          pix_req,
    input  logic [AW-1:0] pix_addr,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    output logic          pix_stolen,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_starve,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          init_busy
);

    localparam logic [CRAM_WAIT_W-1:0] MAX_WAIT_C = CRAM_WAIT_W'(MAX_WAIT);

`ifdef CRAM_CLEAR_EN
    localparam cram_state_t RESET_STATE = S_CLEAR;
    logic [AW-1:0] clr_addr_r;
`else
    localparam cram_state_t RESET_STATE = S_IDLE;
`endif

    cram_state_t            state_r;
    cram_state_t            state_nxt_s;
    logic [CRAM_WAIT_W-1:0] wait_cnt_r;
    logic                   starve_r;

    logic      clearing_s;
    logic      cpu_elig_s;
    logic      cpu_grant_s;
    logic      vid_grant_s;
    logic      steal_s;
    logic      cpu_wr_done_s;
    cram_tag_t tag_s;

    // Grant priority: clear sweep, starved CPU, video, idle CPU
    always_comb begin
        clearing_s    = (state_r == S_CLEAR);
        cpu_elig_s    = (state_r == S_IDLE) && cpu_req;
        cpu_grant_s   = cpu_elig_s && ((wait_cnt_r == MAX_WAIT_C) || !pix_req);
        steal_s       = cpu_grant_s && pix_req;
        vid_grant_s   = pix_req && !cpu_grant_s && !clearing_s;
        cpu_wr_done_s = cpu_grant_s && cpu_we;
    end

    // RAM port mux driven straight from the grant
    always_comb begin
        ram_addr  = {AW{1'b0}};
        ram_we    = 1'b0;
        ram_wdata = {DW{1'b0}};
        if (clearing_s) begin
`ifdef CRAM_CLEAR_EN
            ram_addr = clr_addr_r;
`else
            ram_addr = {AW{1'b0}};
`endif
            ram_we   = 1'b1;
        end else if (cpu_grant_s) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end else if (vid_grant_s) begin
            ram_addr = pix_addr;
        end else begin
            ram_addr = {AW{1'b0}};
        end
    end

    // Tag for the read pipe; every pix_req gets exactly one answer
    always_comb begin
        tag_s = CRAM_TAG_IDLE;
        if (cpu_grant_s && !cpu_we) begin
            // A CPU read may carry a stolen pixel answer along with it
            tag_s.valid  = 1'b1;
            tag_s.owner  = OWN_CPU;
            tag_s.stolen = steal_s;
        end else if (pix_req) begin
            tag_s.valid  = 1'b1;
            tag_s.owner  = OWN_VID;
            tag_s.stolen = steal_s;
            tag_s.blank  = clearing_s;
        end else begin
            tag_s = CRAM_TAG_IDLE;
        end
    end

    // FSM next state; S_REL keeps a held request from being served twice
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_CLEAR: begin
`ifdef CRAM_CLEAR_EN
                if (&clr_addr_r) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_CLEAR;
                end
`else
                state_nxt_s = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (cpu_grant_s) begin
                    state_nxt_s = cpu_we ? S_ACK : S_RD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD:  state_nxt_s = S_ACK;
            S_ACK: state_nxt_s = S_REL;
            S_REL: begin
                if (cpu_req) begin
                    state_nxt_s = S_REL;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CPU wait counter and sticky starvation flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt_r <= {CRAM_WAIT_W{1'b0}};
            starve_r   <= 1'b0;
        end else begin
            if (cpu_grant_s || !cpu_req) begin
                wait_cnt_r <= {CRAM_WAIT_W{1'b0}};
            end else if (state_r == S_IDLE) begin
                wait_cnt_r <= wait_next(wait_cnt_r, MAX_WAIT_C);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (steal_s) begin
                starve_r <= 1'b1;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

`ifdef CRAM_CLEAR_EN
    // Clear sweep address, one word per cycle while in S_CLEAR
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clr_addr_r <= {AW{1'b0}};
        end else if (clearing_s) begin
            clr_addr_r <= clr_addr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            clr_addr_r <= clr_addr_r;
        end
    end

    assign init_busy = clearing_s;
`else
    assign init_busy = 1'b0;
`endif

    assign cpu_starve = starve_r;

    cram_rd_pipe #(
        .DW (DW)
    ) u_rd_pipe (
        .clk         (clk),
        .rst_b       (rst_b),
        .tag_in      (tag_s),
        .cpu_wr_done (cpu_wr_done_s),
        .ram_rdata   (ram_rdata),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_stolen  (pix_stolen),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata)
    );

endmodule

// File: tb/tb_cram_access_arbiter.sv
// Randomized bench for cram_access_arbiter. A RAM model answers the port;
// a transaction-level reference predicts every pixel answer, ack, read word,
// starvation flag and clear sweep from the arbitration rules, cycle by cycle.
module tb_cram_access_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int MAXW = 4;
    localparam int NWORDS = 1024;
`ifdef CRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          pix_req = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_stolen;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_starve;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          init_busy;

    cram_access_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_b(rst_b),
        .pix_req(pix_req), .pix_addr(pix_addr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_stolen(pix_stolen),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starve(cpu_starve),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Color RAM: synchronous read, one cycle latency
    logic [DW-1:0] ram_mem [0:NWORDS-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference state
    logic [DW-1:0] ref_mem [0:NWORDS-1];
    bit            exp_pv [8];
    bit            exp_ps [8];
    logic [DW-1:0] exp_pd [8];
    bit            exp_ack[8];
    bit            exp_rdv[8];
    logic [DW-1:0] exp_rd [8];
    bit            locked;      // CPU served, not yet released by a low request
    int            rel_from;    // first cycle a low request may release it
    int            waited;
    bit            starve;
    logic [DW-1:0] last_pix;
    int            since_rst;
    bit            ag_acked;
    int            ag_hold;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            exp_pv[k] = 1'b0; exp_ps[k] = 1'b0; exp_pd[k] = '0;
            exp_ack[k] = 1'b0; exp_rdv[k] = 1'b0; exp_rd[k] = '0;
        end
        locked = 1'b0; rel_from = 0; waited = 0; starve = 1'b0;
        last_pix = '0; since_rst = 0; ag_acked = 1'b0; ag_hold = 0;
        if (CLR_EN) begin
            for (int k = 0; k < NWORDS; k++) ref_mem[k] = '0;
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 10'h3FF;
            1:       return 10'h000;
            2, 3, 4: return AW'($urandom_range(0, 15));
            default: return AW'($urandom_range(0, NWORDS - 1));
        endcase
    endfunction

    task automatic do_reset();
        pix_req = 1'b0;
        cpu_req = 1'b0;
        rst_b   = 1'b0;
        #1;
        check_val("rst_pix_valid",  32'(pix_valid),  32'd0);
        check_val("rst_pix_stolen", 32'(pix_stolen), 32'd0);
        check_val("rst_pix_data",   32'(pix_data),   32'd0);
        check_val("rst_cpu_ack",    32'(cpu_ack),    32'd0);
        check_val("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
        check_val("rst_cpu_starve", 32'(cpu_starve), 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic run_cycle(input int pix_pct);
        int            s;
        bit            clearing, eligible, cpu_win, stolen;
        logic [DW-1:0] d;
        s = cyc % 8;
        clearing = CLR_EN && (since_rst < NWORDS);

        // Outputs belonging to this cycle
        check_val("pix_valid", 32'(pix_valid), 32'(exp_pv[s]));
        if (exp_pv[s]) begin
            check_val("pix_data",   32'(pix_data),   32'(exp_pd[s]));
            check_val("pix_stolen", 32'(pix_stolen), 32'(exp_ps[s]));
        end
        check_val("cpu_ack", 32'(cpu_ack), 32'(exp_ack[s]));
        if (exp_rdv[s]) check_val("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[s]));
        check_val("cpu_starve", 32'(cpu_starve), 32'(starve));
        check_val("init_busy",  32'(init_busy),  32'(clearing));

        // CPU agent: level request held until ack, then a random extra hold
        if (cpu_req && exp_ack[s] && !ag_acked) begin
            ag_acked = 1'b1;
            ag_hold  = $urandom_range(0, 5);
        end
        if (cpu_req) begin
            if (ag_acked) begin
                if (ag_hold == 0) cpu_req = 1'b0;
                else ag_hold--;
            end else if ($urandom_range(0, 63) == 0) begin
                cpu_req = 1'b0;       // abandoned, before or after its grant
            end
        end else if (!locked && ($urandom_range(0, 99) < 30)) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_addr();
            cpu_wdata = DW'($urandom);
            ag_acked  = 1'b0;
        end
        pix_req  = ($urandom_range(0, 99) < pix_pct);
        pix_addr = pick_addr();

        for (int k = 0; k < 1; k++) begin
            exp_pv[s] = 1'b0; exp_ack[s] = 1'b0; exp_rdv[s] = 1'b0;
        end

        // Arbitration rules
        eligible = !clearing && !locked && cpu_req;
        cpu_win  = eligible && (!pix_req || (waited == MAXW));
        stolen   = cpu_win && pix_req;
        if (pix_req) begin
            if (stolen)        d = last_pix;
            else if (clearing) d = '0;
            else               d = ref_mem[pix_addr];
            last_pix = d;
            exp_pv[(cyc + 2) % 8] = 1'b1;
            exp_pd[(cyc + 2) % 8] = d;
            exp_ps[(cyc + 2) % 8] = stolen;
        end
        if (cpu_win) begin
            locked = 1'b1;
            if (stolen) starve = 1'b1;
            if (cpu_we) begin
                ref_mem[cpu_addr] = cpu_wdata;
                exp_ack[(cyc + 1) % 8] = 1'b1;
                rel_from = cyc + 2;
            end else begin
                exp_ack[(cyc + 2) % 8] = 1'b1;
                exp_rdv[(cyc + 2) % 8] = 1'b1;
                exp_rd[(cyc + 2) % 8]  = ref_mem[cpu_addr];
                rel_from = cyc + 3;
            end
        end
        if (cpu_win || !cpu_req) waited = 0;
        else if (eligible && (waited < MAXW)) waited++;
        if (locked && !cpu_win && (cyc >= rel_from) && !cpu_req) locked = 1'b0;

        #1;
        check_val("ram_we", 32'(ram_we), 32'(clearing || (cpu_win && cpu_we)));
        if (cpu_win && cpu_we) begin
            check_val("ram_waddr", 32'(ram_addr),  32'(cpu_addr));
            check_val("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
        end
        cyc++;
        since_rst++;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < NWORDS; k++) begin
            ram_mem[k] = CLR_EN ? 16'hFFFF : DW'(k * 3);
            ref_mem[k] = DW'(k * 3);
        end
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (1500) run_cycle(95);   // dense video: steals
        repeat (1500) run_cycle(50);
        repeat (1000) run_cycle(10);   // mostly idle video
        repeat (500)  run_cycle(80);
        do_reset();                    // asynchronous reset in mid-traffic
        repeat (2000) run_cycle(70);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
